keypad_entry: RTL and testbench

- User-input counterpart of the multiplexed 7-segment output path: scans a 4x4 matrix keypad by multiplexing row drives, debounces, and decodes keys.
- Assembles decimal keystrokes into a 13-bit unsigned operand, 0..8191.
- Exposes the live entry so the display path can echo it.
- Latches the committed operand with a one-cycle valid pulse for downstream datapath or CPU-lab logic.

---
 rtl/keypad_pkg.sv | 78 +++++++
 rtl/keypad_scan.sv | 139 +++++++++++++
 rtl/keypad_entry.sv | 116 +++++++++++
 tb/tb_keypad_entry.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, defaults and helpers for the keypad entry path
package keypad_pkg;

  localparam logic [3:0] KEY_0   = 4'd0;
  localparam logic [3:0] KEY_1   = 4'd1;
  localparam logic [3:0] KEY_2   = 4'd2;
  localparam logic [3:0] KEY_3   = 4'd3;
  localparam logic [3:0] KEY_4   = 4'd4;
  localparam logic [3:0] KEY_5   = 4'd5;
  localparam logic [3:0] KEY_6   = 4'd6;
  localparam logic [3:0] KEY_7   = 4'd7;
  localparam logic [3:0] KEY_8   = 4'd8;
  localparam logic [3:0] KEY_9   = 4'd9;
  localparam logic [3:0] KEY_BS  = 4'd10;
  localparam logic [3:0] KEY_B   = 4'd11;
  localparam logic [3:0] KEY_C   = 4'd12;
  localparam logic [3:0] KEY_D   = 4'd13;
  localparam logic [3:0] KEY_CLR = 4'd14;
  localparam logic [3:0] KEY_ENT = 4'd15;

  localparam int VALUE_W_DEF   = 13;
  localparam int MAX_VALUE_DEF = 8191;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef enum logic [1:0] {
    FR_NONE  = 2'd0,
    FR_KEY   = 2'd1,
    FR_MULTI = 2'd2
  } frame_cls_e;

  typedef enum logic [0:0] {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } deb_state_e;

  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_0;
    case ({row, col})
      4'h0: code = KEY_1;
      4'h1: code = KEY_2;
      4'h2: code = KEY_3;
      4'h3: code = KEY_BS;
      4'h4: code = KEY_4;
      4'h5: code = KEY_5;
      4'h6: code = KEY_6;
      4'h7: code = KEY_B;
      4'h8: code = KEY_7;
      4'h9: code = KEY_8;
      4'hA: code = KEY_9;
      4'hB: code = KEY_C;
      4'hC: code = KEY_CLR;
      4'hD: code = KEY_0;
      4'hE: code = KEY_ENT;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] low_count(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - row multiplexing, frame classification and press/release debounce
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int CW = $clog2(SCAN_DIV + 1);
  localparam int RW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] RUN_DONE = RW'(DEBOUNCE_FRAMES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [1:0]    acc_q, acc_d;
  logic [3:0]    acc_code_q, acc_code_d;
  deb_state_e    state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic [3:0]    cand_q, cand_d;
  logic          kv_q, kv_d;
  logic [3:0]    kc_q, kc_d;

  logic [3:0]    low_mask;
  logic [2:0]    lows;
  logic [2:0]    sum;
  logic [1:0]    merged_cnt;
  logic [3:0]    merged_code;
  logic          sample_tick;
  logic          frame_end;
  frame_cls_e    cls;
  logic [RW-1:0] run_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      row_q      <= 2'd0;
      acc_q      <= 2'd0;
      acc_code_q <= 4'd0;
      state_q    <= ST_RELEASED;
      run_q      <= '0;
      cand_q     <= 4'd0;
      kv_q       <= 1'b0;
      kc_q       <= 4'd0;
    end else begin
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      acc_q      <= acc_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      run_q      <= run_d;
      cand_q     <= cand_d;
      kv_q       <= kv_d;
      kc_q       <= kc_d;
    end
  end

  // Low-bit count saturates at 2: only "none / one / several" matters per frame.
  always_comb begin
    low_mask    = ~col_n;
    lows        = low_count(low_mask);
    sum         = {1'b0, acc_q} + lows;
    merged_cnt  = (sum > 3'd1) ? 2'd2 : sum[1:0];
    merged_code = (acc_q == 2'd0 && lows == 3'd1) ? key_at(row_q, first_low(low_mask)) : acc_code_q;
    sample_tick = (cnt_q == CNT_LAST);
    frame_end   = sample_tick && (row_q == 2'd3);
    case (merged_cnt)
      2'd0:    cls = FR_NONE;
      2'd1:    cls = FR_KEY;
      default: cls = FR_MULTI;
    endcase

    cnt_d      = cnt_q + CW'(1);
    row_d      = row_q;
    acc_d      = acc_q;
    acc_code_d = acc_code_q;
    state_d    = state_q;
    run_d      = run_q;
    cand_d     = cand_q;
    kv_d       = 1'b0;
    kc_d       = kc_q;
    run_n      = '0;

    if (sample_tick) begin
      cnt_d      = '0;
      row_d      = row_q + 2'd1;
      acc_d      = frame_end ? 2'd0 : merged_cnt;
      acc_code_d = frame_end ? 4'd0 : merged_code;
    end

    if (frame_end) begin
      case (state_q)
        ST_RELEASED: begin
          if (cls == FR_KEY) begin
            run_n  = (run_q != '0 && merged_code == cand_q) ? run_q + RW'(1) : RW'(1);
            cand_d = merged_code;
            if (run_n == RUN_DONE) begin
              state_d = ST_PRESSED;
              run_d   = '0;
              kv_d    = 1'b1;
              kc_d    = merged_code;
            end else begin
              run_d = run_n;
            end
          end else begin
            run_d = '0;
          end
        end
        default: begin
          if (cls == FR_NONE) begin
            run_n = run_q + RW'(1);
            if (run_n == RUN_DONE) begin
              state_d = ST_RELEASED;
              run_d   = '0;
            end else begin
              run_d = run_n;
            end
          end else begin
            run_d = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    row_n     = ~((~ROW_RESET) << row_q);
    key_valid = kv_q;
    key_code  = kc_q;
  end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - decimal operand entry, backspace/clear/enter and committed result
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int VALUE_W         = VALUE_W_DEF,
  parameter int MAX_VALUE       = MAX_VALUE_DEF,
  parameter int MAX_DIGITS      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         col_n,
  output logic [3:0]         row_n,
  output logic [VALUE_W-1:0] entry,
  output logic [2:0]         digit_count,
  output logic [VALUE_W-1:0] result,
  output logic               result_valid,
  output logic               key_valid,
  output logic [3:0]         key_code,
  output logic               reject
);

  localparam int PW = VALUE_W + 4;
  localparam logic [PW-1:0] MAX_V = PW'(MAX_VALUE);
  localparam logic [2:0]    MAX_D = 3'(MAX_DIGITS);

  logic [VALUE_W-1:0] entry_q, entry_d;
  logic [2:0]         count_q, count_d;
  logic [VALUE_W-1:0] result_q, result_d;
  logic               rv_q, rv_d;
  logic               rej_q, rej_d;

  logic [PW-1:0]      appended;
  logic [VALUE_W-1:0] shortened;

  keypad_scan #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q  <= '0;
      count_q  <= 3'd0;
      result_q <= '0;
      rv_q     <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      count_q  <= count_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      rej_q    <= rej_d;
    end
  end

  // Widened append so an overflowing digit is caught before anything is stored.
  always_comb begin
    appended  = PW'(entry_q) * PW'(10) + PW'(key_code);
    shortened = entry_q / VALUE_W'(10);

    entry_d  = entry_q;
    count_d  = count_q;
    result_d = result_q;
    rv_d     = 1'b0;
    rej_d    = 1'b0;

    if (key_valid) begin
      if (key_code <= KEY_9) begin
        if (count_q < MAX_D && appended <= MAX_V) begin
          entry_d = appended[VALUE_W-1:0];
          count_d = count_q + 3'd1;
        end else begin
          rej_d = 1'b1;
        end
      end else begin
        case (key_code)
          KEY_BS: begin
            if (count_q != 3'd0) begin
              entry_d = shortened;
              count_d = count_q - 3'd1;
            end
          end
          KEY_CLR: begin
            entry_d = '0;
            count_d = 3'd0;
          end
          KEY_ENT: begin
            result_d = entry_q;
            rv_d     = 1'b1;
            entry_d  = '0;
            count_d  = 3'd0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    entry        = entry_q;
    digit_count  = count_q;
    result       = result_q;
    result_valid = rv_q;
    reject       = rej_q;
  end

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - scoreboard bench for keypad_entry with a switch-matrix keypad model
module tb_keypad_entry;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [12:0] entry;
  logic [2:0]  digit_count;
  logic [12:0] result;
  logic        result_valid;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        reject;

  logic [15:0] held = 16'h0;

  int n_checks = 0;
  int n_errors = 0;
  int kv_seen  = 0;
  int m_entry  = 0;
  int m_cnt    = 0;
  int kq[$];
  int rq[$];
  int jq[$];

  keypad_entry #(
    .SCAN_DIV        (4),
    .DEBOUNCE_FRAMES (2),
    .VALUE_W         (13),
    .MAX_VALUE       (8191),
    .MAX_DIGITS      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .col_n        (col_n),
    .row_n        (row_n),
    .entry        (entry),
    .digit_count  (digit_count),
    .result       (result),
    .result_valid (result_valid),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .reject       (reject)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int key_pos(input int code);
    case (code)
      0: return 13;  1: return 0;   2: return 1;   3: return 2;
      4: return 4;   5: return 5;   6: return 6;   7: return 8;
      8: return 9;   9: return 10;  10: return 3;  11: return 7;
      12: return 11; 13: return 15; 14: return 12; default: return 14;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        kv_seen++;
        if (kq.size() == 0) check_eq("key_valid_unexpected", 1, 0);
        else check_eq("key_code", int'(key_code), kq.pop_front());
      end
      if (result_valid) begin
        if (rq.size() == 0) check_eq("result_valid_unexpected", 1, 0);
        else check_eq("result", int'(result), rq.pop_front());
      end
      if (reject) begin
        if (jq.size() == 0) check_eq("reject_unexpected", 1, 0);
        else void'(jq.pop_front());
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_key(input int code);
    kq.push_back(code);
    if (code <= 9) begin
      if (m_cnt < 4 && m_entry * 10 + code <= 8191) begin
        m_entry = m_entry * 10 + code;
        m_cnt++;
      end else begin
        jq.push_back(1);
      end
    end else if (code == 10) begin
      if (m_cnt > 0) begin
        m_entry = m_entry / 10;
        m_cnt--;
      end
    end else if (code == 14) begin
      m_entry = 0;
      m_cnt = 0;
    end else if (code == 15) begin
      rq.push_back(m_entry);
      m_entry = 0;
      m_cnt = 0;
    end
  endtask

  task automatic press_key(input int code);
    model_key(code);
    held[key_pos(code)] = 1'b1;
    wait_cycles(4 * FRAME);
    held = 16'h0;
    wait_cycles(4 * FRAME);
    check_eq("entry", int'(entry), m_entry);
    check_eq("digit_count", int'(digit_count), m_cnt);
  endtask

  task automatic align_frame();
    int n = 0;
    while (row_n != 4'b0111 && n < 100) begin @(negedge clk); n++; end
    while (row_n != 4'b1110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check_eq("align_timeout", 0, 1);
  endtask

  initial begin
    int kv0;
    wait_cycles(3);
    check_eq("rst_row_n", int'(row_n), 4'b1110);
    check_eq("rst_entry", int'(entry), 0);
    check_eq("rst_count", int'(digit_count), 0);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_pulses", int'({key_valid, result_valid, reject}), 0);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k % 4 == 0 || k == 3) check_eq("row_rotate", int'(row_n), int'(~(4'b0001 << ((k / 4) % 4)) & 4'hF));
    end

    kv0 = kv_seen;
    press_key(5);
    check_eq("kv_once_5", kv_seen - kv0, 1);
    check_eq("entry_5", int'(entry), 5);
    press_key(14);

    press_key(8); press_key(1); press_key(9); press_key(1);
    check_eq("entry_8191", int'(entry), 8191);
    press_key(15);
    check_eq("result_8191", int'(result), 8191);
    check_eq("entry_after_enter", int'(entry), 0);

    press_key(8); press_key(1); press_key(9); press_key(2);
    check_eq("entry_819", int'(entry), 819);
    check_eq("count_819", int'(digit_count), 3);
    press_key(14);
    press_key(1); press_key(2); press_key(3); press_key(4); press_key(5);
    check_eq("entry_1234", int'(entry), 1234);
    press_key(14);

    press_key(4); press_key(2);
    press_key(10); check_eq("bs_4", int'(entry), 4);
    press_key(10); check_eq("bs_0", int'(digit_count), 0);
    press_key(10); check_eq("bs_noop", int'(entry), 0);
    press_key(7); press_key(7); press_key(14);
    check_eq("clear_77", int'(entry), 0);

    press_key(11);
    press_key(0); press_key(0);
    check_eq("lead_zero_count", int'(digit_count), 2);
    press_key(7); press_key(15);
    check_eq("result_7", int'(result), 7);

    align_frame();
    kv0 = kv_seen;
    held[key_pos(3)] = 1'b1;
    wait_cycles(FRAME);
    held = 16'h0;
    wait_cycles(FRAME);
    check_eq("bounce_no_kv", kv_seen - kv0, 0);
    model_key(3);
    held[key_pos(3)] = 1'b1;
    wait_cycles(2 * FRAME + 8);
    check_eq("bounce_kv", kv_seen - kv0, 1);
    held = 16'h0;
    wait_cycles(4 * FRAME);
    check_eq("bounce_entry", int'(entry), 3);

    kv0 = kv_seen;
    held[key_pos(1)] = 1'b1;
    held[key_pos(2)] = 1'b1;
    wait_cycles(5 * FRAME);
    held = 16'h0;
    wait_cycles(4 * FRAME);
    check_eq("multi_no_kv", kv_seen - kv0, 0);
    check_eq("multi_entry", int'(entry), 3);
    press_key(14);

    press_key(1); press_key(2);
    check_eq("entry_12", int'(entry), 12);
    held[key_pos(6)] = 1'b1;
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(2);
    check_eq("mid_rst_row_n", int'(row_n), 4'b1110);
    check_eq("mid_rst_entry", int'(entry), 0);
    check_eq("mid_rst_result", int'(result), 0);
    m_entry = 0;
    m_cnt = 0;
    kv0 = kv_seen;
    rst = 1'b0;
    model_key(6);
    wait_cycles(4 * FRAME);
    check_eq("held_rst_entry", int'(entry), 6);
    held = 16'h0;
    wait_cycles(4 * FRAME);
    check_eq("held_rst_kv_once", kv_seen - kv0, 1);
    check_eq("held_rst_result", int'(result), 0);

    check_eq("kq_left", kq.size(), 0);
    check_eq("rq_left", rq.size(), 0);
    check_eq("jq_left", jq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
